// File: rtl/addsub_flag_buffer.sv
// Flag-deriving FIFO stage behind the add/subtract unit: computes C/V/Z/N at push time
// and queues result plus flags for a consumer that may stall.
module addsub_flag_buffer #(
  parameter int W     = 4,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     mode,
  input  logic                     a_msb,
  input  logic                     b_msb,
  input  logic [W-1:0]             s,
  input  logic                     cout,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [W-1:0]             out_s,
  output logic                     out_c,
  output logic                     out_v,
  output logic                     out_z,
  output logic                     out_n,
  output logic                     out_mode,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

  typedef struct packed {
    logic         mode;
    logic         n;
    logic         z;
    logic         v;
    logic         c;
    logic [W-1:0] s;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        newEntry;
  entry_t        headEntry;
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic          push, pop;
  logic          dMsb;

  // The adder sees B already inverted in subtract mode, so overflow uses the effective MSB.
  always_comb begin
    dMsb          = b_msb ^ mode;
    newEntry      = '0;
    newEntry.s    = s;
    newEntry.c    = cout ^ mode;
    newEntry.v    = (a_msb == dMsb) & (s[W-1] != a_msb);
    newEntry.z    = ~|s;
    newEntry.n    = s[W-1];
    newEntry.mode = mode;
  end

  assign in_ready  = ~rst & (count_q != FullCount);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = tail_q + AW'(1);
    if (pop)  head_d = head_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: empty slots are never visible because outputs are masked.
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= newEntry;
  end

  assign headEntry = out_valid ? mem_q[head_q] : '0;

  assign out_s    = headEntry.s;
  assign out_c    = headEntry.c;
  assign out_v    = headEntry.v;
  assign out_z    = headEntry.z;
  assign out_n    = headEntry.n;
  assign out_mode = headEntry.mode;
  assign count    = count_q;

endmodule

// File: tb/tb_addsub_flag_buffer.sv
// Self-checking bench for addsub_flag_buffer: directed scenarios then randomized traffic,
// checked against a queue model whose flags come from plain signed/unsigned arithmetic.
module tb_addsub_flag_buffer;

  localparam int W     = 4;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          mode;
  logic          a_msb;
  logic          b_msb;
  logic [W-1:0]  s;
  logic          cout;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_s;
  logic          out_c;
  logic          out_v;
  logic          out_z;
  logic          out_n;
  logic          out_mode;
  logic [CW-1:0] count;

  addsub_flag_buffer #(.W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .a_msb(a_msb), .b_msb(b_msb), .s(s), .cout(cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_s(out_s),
    .out_c(out_c), .out_v(out_v), .out_z(out_z), .out_n(out_n),
    .out_mode(out_mode), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] s;
    logic       c;
    logic       v;
    logic       z;
    logic       n;
    logic       mode;
  } entry_t;

  entry_t model[$];
  int     vectors     = 0;
  int     miscompares = 0;
  int     opA, opB;
  logic   opMode;
  bit     lastPushed;

  // Drive one operation as the adder would present it, plus handshake and reset.
  task automatic applyStimulus(input logic valid, input int a, input int b,
                               input logic m, input logic ordy, input logic r);
    int sum;
    opA    = a;
    opB    = b;
    opMode = m;
    sum    = m ? (a + 16 - b) : (a + b);
    in_valid  = valid;
    out_ready = ordy;
    rst       = r;
    mode      = m;
    a_msb     = a[3];
    b_msb     = b[3];
    s         = sum[3:0];
    cout      = sum[4];
  endtask

  // Reference flags from the arithmetic meaning of the operation.
  function automatic entry_t expectedEntry(input int a, input int b, input logic m);
    entry_t e;
    int sa, sb, r, u;
    sa = (a >= 8) ? a - 16 : a;
    sb = (b >= 8) ? b - 16 : b;
    r  = m ? sa - sb : sa + sb;
    u  = m ? a - b : a + b;
    e.s    = u[3:0];
    e.c    = m ? (a < b) : (u > 15);
    e.v    = (r < -8) || (r > 7);
    e.z    = (u[3:0] == 4'd0);
    e.n    = u[3];
    e.mode = m;
    return e;
  endfunction

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    entry_t h;
    logic   expValid;
    expValid = (model.size() > 0);
    if (expValid) h = model[0];
    else          h = '{s: 4'd0, c: 1'b0, v: 1'b0, z: 1'b0, n: 1'b0, mode: 1'b0};
    compare("out_valid", 32'(out_valid), 32'(expValid));
    compare("out_s",     32'(out_s),     32'(h.s));
    compare("out_c",     32'(out_c),     32'(h.c));
    compare("out_v",     32'(out_v),     32'(h.v));
    compare("out_z",     32'(out_z),     32'(h.z));
    compare("out_n",     32'(out_n),     32'(h.n));
    compare("out_mode",  32'(out_mode),  32'(h.mode));
    compare("count",     32'(count),     32'(model.size()));
    compare("in_ready",  32'(in_ready),  32'(!rst && model.size() != DEPTH));
  endtask

  // Advance one clock edge, update the model the way the queue should behave, then check.
  task automatic step();
    bit doPush, doPop;
    doPush = in_valid && !rst && (model.size() < DEPTH);
    doPop  = !rst && out_ready && (model.size() > 0);
    @(posedge clk);
    #1;
    if (rst) begin
      model.delete();
      doPush = 1'b0;
    end else begin
      if (doPop)  void'(model.pop_front());
      if (doPush) model.push_back(expectedEntry(opA, opB, opMode));
    end
    lastPushed = doPush;
    checkOutput();
  endtask

  int bpA[3] = '{1, 9, 15};
  int bpB[3] = '{2, 4, 15};
  int bpM[3] = '{0, 1, 0};

  initial begin
    int   idx;
    int   ra, rb;
    logic rm, rv;

    $display("[TB] reset");
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, 1'b1);
    step();
    step();
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
    step();

    $display("[TB] directed flag cases");
    applyStimulus(1'b1, 5, 14, 1'b0, 1'b1, 1'b0); step();
    applyStimulus(1'b0, 5, 14, 1'b0, 1'b1, 1'b0); step();
    applyStimulus(1'b1, 5, 14, 1'b1, 1'b1, 1'b0); step();
    applyStimulus(1'b0, 5, 14, 1'b1, 1'b1, 1'b0); step();
    applyStimulus(1'b1, 7, 1, 1'b0, 1'b1, 1'b0);  step();
    applyStimulus(1'b0, 7, 1, 1'b0, 1'b1, 1'b0);  step();
    applyStimulus(1'b1, 3, 3, 1'b1, 1'b1, 1'b0);  step();
    applyStimulus(1'b0, 3, 3, 1'b1, 1'b1, 1'b0);  step();

    $display("[TB] backpressure");
    idx = 0;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, bpA[idx], bpB[idx], bpM[idx][0], 1'b0, 1'b0);
      step();
      if (lastPushed) idx++;
    end
    for (int k = 0; k < 8; k++) begin
      if (idx < 3) applyStimulus(1'b1, bpA[idx], bpB[idx], bpM[idx][0], 1'b1, 1'b0);
      else         applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
      step();
      if (lastPushed) idx++;
    end

    $display("[TB] simultaneous push/pop across wrap");
    applyStimulus(1'b1, 6, 2, 1'b1, 1'b0, 1'b0);
    step();
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, (k * 3) % 16, (k * 5 + 1) % 16, k[0], 1'b1, 1'b0);
      step();
    end
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
    step();

    $display("[TB] reset while full");
    applyStimulus(1'b1, 8, 8, 1'b0, 1'b0, 1'b0); step();
    applyStimulus(1'b1, 2, 9, 1'b1, 1'b0, 1'b0); step();
    applyStimulus(1'b1, 4, 4, 1'b0, 1'b0, 1'b1); step();
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'b0); step();

    $display("[TB] random traffic");
    rv = 1'b0;
    ra = 0; rb = 0; rm = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (!(rv && !lastPushed)) begin
        rv = ($urandom_range(0, 3) != 0);
        ra = int'($urandom_range(0, 15));
        rb = int'($urandom_range(0, 15));
        rm = $urandom_range(0, 1) == 1;
      end
      applyStimulus(rv, ra, rb, rm, $urandom_range(0, 2) != 0, $urandom_range(0, 99) == 0);
      step();
      if (rst) rv = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
